// File: rtl/prog_ctr_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prog_ctr_multi : multi-program PC sequencer with branch/jump/stall and   |
// |                  optional return stack (enable with PC_RETSTACK_EN).     |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module prog_ctr_multi #(
  parameter int               L           = 10,
  parameter int               OW          = 8,
  parameter int               NPROG       = 4,
  parameter logic [NPROG*L-1:0] PROG_BASE = {10'd570, 10'd380, 10'd190, 10'd0},
  parameter int               STACK_DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic                         Halt,
  input  logic                         Stall,
  input  logic                         Jump,
  input  logic                         BranchUp,
  input  logic                         BranchDown,
  input  logic                         Call,
  input  logic                         Ret,
  input  logic [OW-1:0]                PCTarget,
  input  logic [L-1:0]                 JumpTarget,
  output logic [L-1:0]                 ProgCtr,
  output logic [$clog2(NPROG+1)-1:0]   ProgIdx,
  output logic                         Running,
  output logic                         Done,
  output logic                         AllDone,
  output logic                         StackErr
);

  localparam int c_idx_w = $clog2(NPROG+1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_REL = 2'd1,
    S_RUN      = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  state_t             r_state;
  logic [L-1:0]       r_pc;
  logic [c_idx_w-1:0] r_idx;
  logic               r_running;
  logic               r_done;
  logic               r_all_done;

  logic [L-1:0]       w_offset;
  logic [L-1:0]       w_pc_inc;
  logic [L-1:0]       w_base;
  logic [c_idx_w-1:0] w_idx_next;

  assign w_offset   = L'(PCTarget);
  assign w_pc_inc   = r_pc + L'(1);
  assign w_idx_next = r_idx + c_idx_w'(1);

  always_comb begin
    w_base = '0;
    for (int k = 0; k < NPROG; k++) begin
      if (r_idx == c_idx_w'(k)) w_base = PROG_BASE[k*L +: L];
    end
  end

`ifdef PC_RETSTACK_EN
  localparam int c_sp_w = $clog2(STACK_DEPTH+1);

  logic [L-1:0]      r_stack [STACK_DEPTH];
  logic [c_sp_w-1:0] r_sp;
  logic              r_stack_err;
  logic [L-1:0]      w_top;
  logic              w_full;
  logic              w_empty;

  assign w_full   = (r_sp == c_sp_w'(STACK_DEPTH));
  assign w_empty  = (r_sp == '0);
  assign StackErr = r_stack_err;

  always_comb begin
    w_top = '0;
    for (int k = 0; k < STACK_DEPTH; k++) begin
      if (r_sp == c_sp_w'(k + 1)) w_top = r_stack[k];
    end
  end
`else
  localparam int c_unused_depth = STACK_DEPTH;
  wire w_unused_callret = &{1'b0, Call, Ret};
  assign StackErr = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_idx      <= '0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_all_done <= 1'b0;
`ifdef PC_RETSTACK_EN
      r_sp        <= '0;
      r_stack_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_HALTED: begin
          if (Start && !r_all_done) r_state <= S_WAIT_REL;
        end
        S_WAIT_REL: begin
          if (!Start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_pc      <= w_base;
`ifdef PC_RETSTACK_EN
            r_sp      <= '0;
`endif
          end
        end
        S_RUN: begin
          // Start wins over everything so a held Start always restarts the program
          if (Start) begin
            r_state   <= S_WAIT_REL;
            r_running <= 1'b0;
          end else if (Halt) begin
            r_state   <= S_HALTED;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_idx     <= w_idx_next;
            if (w_idx_next == c_idx_w'(NPROG)) r_all_done <= 1'b1;
          end else if (Stall) begin
            r_pc <= r_pc;
          end else if (Jump) begin
            r_pc <= JumpTarget;
          end else if (BranchUp) begin
            r_pc <= r_pc - w_offset;
          end else if (BranchDown) begin
            r_pc <= r_pc + w_offset;
`ifdef PC_RETSTACK_EN
          end else if (Call) begin
            r_pc <= JumpTarget;
            if (w_full) begin
              r_stack_err <= 1'b1;
            end else begin
              for (int k = 0; k < STACK_DEPTH; k++) begin
                if (r_sp == c_sp_w'(k)) r_stack[k] <= w_pc_inc;
              end
              r_sp <= r_sp + c_sp_w'(1);
            end
          end else if (Ret) begin
            if (w_empty) begin
              r_pc        <= w_pc_inc;
              r_stack_err <= 1'b1;
            end else begin
              r_pc <= w_top;
              r_sp <= r_sp - c_sp_w'(1);
            end
`endif
          end else begin
            r_pc <= w_pc_inc;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign ProgCtr = r_pc;
  assign ProgIdx = r_idx;
  assign Running = r_running;
  assign Done    = r_done;
  assign AllDone = r_all_done;

endmodule
`default_nettype wire
